// File: rtl/fir_channel_scheduler_if.sv
// Handshake bundle between the channel scheduler and the shared AXI-stream FIR.
// The master side drives the FIR slave port and receives the FIR master port.
interface fir_channel_scheduler_if #(
    parameter int unsigned WIDTH = 16
);
    logic             fir_tvalid_out;
    logic             fir_tready_in;
    logic [WIDTH-1:0] fir_tdata_out;
    logic             fir_res_valid_in;
    logic [WIDTH-1:0] fir_res_data_in;

    modport master (
        output fir_tvalid_out,
        output fir_tdata_out,
        input  fir_tready_in,
        input  fir_res_valid_in,
        input  fir_res_data_in
    );

    modport slave (
        input  fir_tvalid_out,
        input  fir_tdata_out,
        output fir_tready_in,
        output fir_res_valid_in,
        output fir_res_data_in
    );
endinterface

// File: rtl/fir_channel_scheduler.sv
// Shares one in-order AXI-stream FIR across NUM_CH mic channels with round-robin issue and a tag
// FIFO that routes results back. Define FIR_SCHED_STATS_EN to add the drop_count_out counter.
module fir_channel_scheduler #(
    parameter int unsigned NUM_CH    = 3,
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned TAG_DEPTH = 4
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic [NUM_CH-1:0]       ch_valid_in,
    input  logic [NUM_CH*WIDTH-1:0] ch_data_in,
    fir_channel_scheduler_if.master fir,
    output logic [NUM_CH-1:0]       ch_valid_out,
    output logic [NUM_CH*WIDTH-1:0] ch_data_out,
    output logic [NUM_CH-1:0]       overrun_out,
    output logic                    orphan_err_out
`ifdef FIR_SCHED_STATS_EN
    ,
    output logic [15:0]             drop_count_out
`endif
);

    localparam int unsigned CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned PW = $clog2(TAG_DEPTH);
    localparam int unsigned NW = PW + 1;

    logic [WIDTH-1:0]  hold_q [NUM_CH];
    logic [NUM_CH-1:0] pending_q;
    logic [NUM_CH-1:0] pending_d;
    logic [NUM_CH-1:0] overrun_evt;
    logic [NUM_CH-1:0] res_strobe;
    logic [CW-1:0]     rr_q;
    logic [CW-1:0]     grant_chan;
    logic [CW-1:0]     cand;
    logic              grant_found;

    logic              slot_valid_q;
    logic [CW-1:0]     slot_chan_q;
    logic [WIDTH-1:0]  slot_data_q;

    logic [CW-1:0]     tag_mem_q [TAG_DEPTH];
    logic [PW-1:0]     wr_ptr_q;
    logic [PW-1:0]     rd_ptr_q;
    logic [NW-1:0]     tag_cnt_q;
    logic [NW-1:0]     tag_cnt_d;
    logic [CW-1:0]     tag_head;

    logic handshake;
    logic push;
    logic pop;
    logic orphan;
    logic slot_free;
    logic load;

    assign fir.fir_tvalid_out = slot_valid_q;
    assign fir.fir_tdata_out  = slot_data_q;

    assign handshake = slot_valid_q & fir.fir_tready_in;
    assign push      = handshake;
    assign pop       = fir.fir_res_valid_in & (tag_cnt_q != '0);
    assign orphan    = fir.fir_res_valid_in & (tag_cnt_q == '0);
    assign tag_head  = tag_mem_q[rd_ptr_q];
    assign slot_free = ~slot_valid_q | handshake;

    always_comb begin
        tag_cnt_d = tag_cnt_q;
        if (push && !pop) begin
            tag_cnt_d = tag_cnt_q + NW'(1);
        end else if (!push && pop) begin
            tag_cnt_d = tag_cnt_q - NW'(1);
        end
    end

    // Gating on next-cycle occupancy keeps the slot occupant counted, so a
    // sample never sits in the slot when its tag could not be pushed.
    assign load = slot_free & grant_found & (tag_cnt_d < NW'(TAG_DEPTH));

    always_comb begin
        grant_found = 1'b0;
        grant_chan  = '0;
        cand        = '0;
        for (int k = 1; k <= int'(NUM_CH); k++) begin
            cand = CW'((int'(rr_q) + k) % int'(NUM_CH));
            if (!grant_found && pending_q[cand]) begin
                grant_found = 1'b1;
                grant_chan  = cand;
            end
        end
    end

    always_comb begin
        pending_d   = '0;
        overrun_evt = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (load && (grant_chan == CW'(i))) begin
                pending_d[i] = ch_valid_in[i];
            end else begin
                pending_d[i]   = pending_q[i] | ch_valid_in[i];
                overrun_evt[i] = pending_q[i] & ch_valid_in[i];
            end
        end
    end

    always_comb begin
        res_strobe = '0;
        if (pop) begin
            res_strobe = NUM_CH'(1) << tag_head;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                hold_q[i] <= '0;
            end
            pending_q      <= '0;
            rr_q           <= CW'(NUM_CH - 1);
            slot_valid_q   <= 1'b0;
            slot_chan_q    <= '0;
            slot_data_q    <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            tag_cnt_q      <= '0;
            ch_valid_out   <= '0;
            ch_data_out    <= '0;
            overrun_out    <= '0;
            orphan_err_out <= 1'b0;
        end else begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                if (ch_valid_in[i]) begin
                    hold_q[i] <= ch_data_in[i*WIDTH +: WIDTH];
                end
            end
            pending_q   <= pending_d;
            overrun_out <= overrun_out | overrun_evt;

            if (load) begin
                slot_valid_q <= 1'b1;
                slot_chan_q  <= grant_chan;
                slot_data_q  <= hold_q[grant_chan];
                rr_q         <= grant_chan;
            end else if (handshake) begin
                slot_valid_q <= 1'b0;
            end

            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
                ch_data_out[int'(tag_head)*WIDTH +: WIDTH] <= fir.fir_res_data_in;
            end
            tag_cnt_q    <= tag_cnt_d;
            ch_valid_out <= res_strobe;

            if (orphan) begin
                orphan_err_out <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (push) begin
            tag_mem_q[wr_ptr_q] <= slot_chan_q;
        end
    end

`ifdef FIR_SCHED_STATS_EN
    logic [16:0] drop_sum;

    assign drop_sum = {1'b0, drop_count_out} + 17'($countones(overrun_evt)) + 17'(orphan);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            drop_count_out <= '0;
        end else begin
            drop_count_out <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end
`endif

endmodule

// File: tb/tb_fir_channel_scheduler.sv
// Directed bench for fir_channel_scheduler: expected issues and routed results are queued as
// stimulus is driven and checked by a negedge monitor, plus inline checks of timing and flags.
module tb_fir_channel_scheduler;

    localparam int unsigned NUM_CH    = 3;
    localparam int unsigned WIDTH     = 16;
    localparam int unsigned TAG_DEPTH = 4;

    logic                    audio_clk = 1'b0;
    logic                    rst;
    logic [NUM_CH-1:0]       ch_valid;
    logic [NUM_CH*WIDTH-1:0] ch_data;
    logic [NUM_CH-1:0]       ch_valid_out;
    logic [NUM_CH*WIDTH-1:0] ch_data_out;
    logic [NUM_CH-1:0]       overrun;
    logic                    orphan_err;
`ifdef FIR_SCHED_STATS_EN
    logic [15:0]             drop_count;
`endif

    fir_channel_scheduler_if #(.WIDTH(WIDTH)) fir_if ();

    fir_channel_scheduler #(
        .NUM_CH   (NUM_CH),
        .WIDTH    (WIDTH),
        .TAG_DEPTH(TAG_DEPTH)
    ) dut (
        .clk_in        (audio_clk),
        .rst_in        (rst),
        .ch_valid_in   (ch_valid),
        .ch_data_in    (ch_data),
        .fir           (fir_if),
        .ch_valid_out  (ch_valid_out),
        .ch_data_out   (ch_data_out),
        .overrun_out   (overrun),
        .orphan_err_out(orphan_err)
`ifdef FIR_SCHED_STATS_EN
        ,
        .drop_count_out(drop_count)
`endif
    );

    always #5 audio_clk = ~audio_clk;

    typedef struct {
        int unsigned      chan;
        logic [WIDTH-1:0] data;
    } item_t;

    item_t       exp_issue[$];
    item_t       exp_res[$];
    int unsigned tag_model[$];
    int          n_cmp    = 0;
    int          n_err    = 0;
    int          hs_count = 0;
    int          base;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Handshakes consume the issue queue and feed the tag model; result strobes consume exp_res.
    always @(negedge audio_clk) begin
        item_t e;
        if (!rst) begin
            if (fir_if.fir_tvalid_out && fir_if.fir_tready_in) begin
                hs_count++;
                if (exp_issue.size() == 0) begin
                    check("issue_unexpected", 64'(fir_if.fir_tvalid_out), 64'd0);
                end else begin
                    e = exp_issue.pop_front();
                    check("issue_data", 64'(fir_if.fir_tdata_out), 64'(e.data));
                    tag_model.push_back(e.chan);
                end
            end
            for (int i = 0; i < int'(NUM_CH); i++) begin
                if (ch_valid_out[i]) begin
                    if (exp_res.size() == 0) begin
                        check("res_unexpected", 64'(ch_valid_out[i]), 64'd0);
                    end else begin
                        e = exp_res.pop_front();
                        check("res_chan", 64'(i), 64'(e.chan));
                        check("res_data", 64'(ch_data_out[i*WIDTH +: WIDTH]), 64'(e.data));
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge audio_clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_issue.delete();
        exp_res.delete();
        tag_model.delete();
    endtask

    task automatic expect_issue(input int unsigned ch, input logic [WIDTH-1:0] d);
        item_t it;
        it.chan = ch;
        it.data = d;
        exp_issue.push_back(it);
    endtask

    task automatic strobe(input logic [NUM_CH-1:0] v, input logic [WIDTH-1:0] d0,
                          input logic [WIDTH-1:0] d1, input logic [WIDTH-1:0] d2);
        ch_valid = v;
        ch_data  = {d2, d1, d0};
        tick();
        ch_valid = '0;
    endtask

    task automatic send_result(input logic [WIDTH-1:0] d);
        item_t it;
        if (tag_model.size() > 0) begin
            it.chan = tag_model.pop_front();
            it.data = d;
            exp_res.push_back(it);
        end
        fir_if.fir_res_valid_in = 1'b1;
        fir_if.fir_res_data_in  = d;
        tick();
        fir_if.fir_res_valid_in = 1'b0;
    endtask

    task automatic wait_hs(input int target, input int budget, input string tag);
        int n = 0;
        while (hs_count < target && n < budget) begin
            tick();
            n++;
        end
        check(tag, 64'(hs_count), 64'(target));
    endtask

    initial begin
        rst                     = 1'b1;
        ch_valid                = '0;
        ch_data                 = '0;
        fir_if.fir_tready_in    = 1'b0;
        fir_if.fir_res_valid_in = 1'b0;
        fir_if.fir_res_data_in  = '0;
        tick();
        tick();
        rst = 1'b0;

        check("rst_tvalid", 64'(fir_if.fir_tvalid_out), 64'd0);
        check("rst_ch_valid", 64'(ch_valid_out), 64'd0);
        check("rst_ch_data", 64'(ch_data_out), 64'd0);
        check("rst_overrun", 64'(overrun), 64'd0);
        check("rst_orphan", 64'(orphan_err), 64'd0);

        // Single sample: latency N+2, result routed to ch0 one cycle later.
        fir_if.fir_tready_in = 1'b1;
        base = hs_count;
        expect_issue(0, 16'h1234);
        strobe(3'b001, 16'h1234, 16'h0, 16'h0);
        check("lat_n1_tvalid", 64'(fir_if.fir_tvalid_out), 64'd0);
        tick();
        check("lat_n2_tvalid", 64'(fir_if.fir_tvalid_out), 64'd1);
        check("lat_n2_tdata", 64'(fir_if.fir_tdata_out), 64'h1234);
        wait_hs(base + 1, 5, "single_hs");
        send_result(16'h0ABC);
        check("single_res_valid", 64'(ch_valid_out), 64'b001);
        check("single_res_data", 64'(ch_data_out[15:0]), 64'h0ABC);
        tick();
        check("single_strobe_len", 64'(ch_valid_out), 64'd0);

        // Round-robin from a fresh pointer: ch0, ch1, ch2 back to back.
        do_reset();
        fir_if.fir_tready_in = 1'b1;
        expect_issue(0, 16'd1);
        expect_issue(1, 16'd2);
        expect_issue(2, 16'd3);
        strobe(3'b111, 16'd1, 16'd2, 16'd3);
        tick();
        check("rr_0", 64'(fir_if.fir_tdata_out), 64'd1);
        tick();
        check("rr_1", 64'(fir_if.fir_tdata_out), 64'd2);
        tick();
        check("rr_2", 64'(fir_if.fir_tdata_out), 64'd3);
        check("rr_2_tvalid", 64'(fir_if.fir_tvalid_out), 64'd1);
        tick();
        check("rr_idle", 64'(fir_if.fir_tvalid_out), 64'd0);
        send_result(16'd10);
        send_result(16'd20);
        send_result(16'd30);
        tick();
        check("rr_outputs", 64'(ch_data_out), {16'd0, 16'd30, 16'd20, 16'd10});

        // Backpressure: tdata holds; ch1 overwritten and newest value issued.
        do_reset();
        fir_if.fir_tready_in = 1'b0;
        base = hs_count;
        expect_issue(0, 16'hA0A0);
        expect_issue(1, 16'hB2B2);
        strobe(3'b001, 16'hA0A0, 16'h0, 16'h0);
        tick();
        strobe(3'b010, 16'h0, 16'hB1B1, 16'h0);
        strobe(3'b010, 16'h0, 16'hB2B2, 16'h0);
        for (int c = 0; c < 5; c++) begin
            check("bp_tvalid", 64'(fir_if.fir_tvalid_out), 64'd1);
            check("bp_tdata", 64'(fir_if.fir_tdata_out), 64'hA0A0);
            tick();
        end
        check("bp_overrun", 64'(overrun), 64'b010);
        fir_if.fir_tready_in = 1'b1;
        wait_hs(base + 2, 10, "bp_hs");
        send_result(16'h0F00);
        send_result(16'h0F01);
        tick();
        check("bp_overrun_sticky", 64'(overrun), 64'b010);

        // Tag FIFO full: 4 handshakes then stall; one result frees one issue.
        do_reset();
        fir_if.fir_tready_in = 1'b1;
        base = hs_count;
        expect_issue(0, 16'h11);
        expect_issue(1, 16'h12);
        expect_issue(2, 16'h13);
        expect_issue(0, 16'h21);
        expect_issue(1, 16'h22);
        strobe(3'b111, 16'h11, 16'h12, 16'h13);
        repeat (3) tick();
        strobe(3'b111, 16'h21, 16'h22, 16'h23);
        repeat (8) tick();
        check("full_hs", 64'(hs_count - base), 64'd4);
        check("full_tvalid", 64'(fir_if.fir_tvalid_out), 64'd0);
        check("full_overrun", 64'(overrun), 64'd0);
        send_result(16'h5A5A);
        repeat (6) tick();
        check("full_one_more", 64'(hs_count - base), 64'd5);
        check("full_tvalid2", 64'(fir_if.fir_tvalid_out), 64'd0);
        check("full_issue_q", 64'(exp_issue.size()), 64'd0);

        // Mid-cycle async reset with a held tvalid, then stale results become orphans.
        do_reset();
        fir_if.fir_tready_in = 1'b1;
        base = hs_count;
        expect_issue(0, 16'h51);
        expect_issue(1, 16'h52);
        strobe(3'b011, 16'h51, 16'h52, 16'h0);
        wait_hs(base + 2, 10, "orph_hs");
        fir_if.fir_tready_in = 1'b0;
        strobe(3'b100, 16'h0, 16'h0, 16'h53);
        tick();
        check("orph_held", 64'(fir_if.fir_tvalid_out), 64'd1);
        #3;
        rst = 1'b1;
        #1;
        check("orph_rst_tvalid", 64'(fir_if.fir_tvalid_out), 64'd0);
        check("orph_rst_data", 64'(fir_if.fir_tdata_out), 64'd0);
        check("orph_rst_outs", 64'(ch_data_out), 64'd0);
        tick();
        rst = 1'b0;
        exp_issue.delete();
        exp_res.delete();
        tag_model.delete();
        fir_if.fir_tready_in = 1'b1;
        send_result(16'hDEAD);
        check("orph_no_valid1", 64'(ch_valid_out), 64'd0);
        check("orph_err", 64'(orphan_err), 64'd1);
        send_result(16'hBEEF);
        check("orph_no_valid2", 64'(ch_valid_out), 64'd0);
        tick();
        check("orph_idle", 64'(fir_if.fir_tvalid_out), 64'd0);
`ifdef FIR_SCHED_STATS_EN
        check("orph_drop_count", 64'(drop_count), 64'd2);
`endif

        // Same-cycle load and capture on ch0: both samples issue, no overrun.
        do_reset();
        fir_if.fir_tready_in = 1'b1;
        base = hs_count;
        expect_issue(0, 16'h61);
        expect_issue(0, 16'h62);
        strobe(3'b001, 16'h61, 16'h0, 16'h0);
        strobe(3'b001, 16'h62, 16'h0, 16'h0);
        wait_hs(base + 2, 10, "same_hs");
        repeat (3) tick();
        check("same_hs_exact", 64'(hs_count - base), 64'd2);
        check("same_overrun", 64'(overrun), 64'd0);
        send_result(16'h1111);
        send_result(16'h2222);
        tick();
        check("same_ch0_data", 64'(ch_data_out[15:0]), 64'h2222);

        check("end_issue_q", 64'(exp_issue.size()), 64'd0);
        check("end_res_q", 64'(exp_res.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fir_channel_scheduler.md
Name: fir_channel_scheduler

Overview:
Time-multiplexes one AXI-stream FIR instance (the input anti-alias filter) across all microphone channels, so a single filter serves every i2s mic. Per-channel samples are buffered and granted round-robin to the filter's slave port. Results from the filter's master port are routed back to per-channel output registers with one-cycle valid strobes. Sits between the i2s receivers and the downstream audio consumers (sos_dist_calculator, pdm mux), clocked on audio_clk.

Parameters:
NUM_CH, 3, number of requesting mic channels (2..8)
WIDTH, 16, sample width in bits (signed, passed through unmodified)
TAG_DEPTH, 4, maximum samples in flight inside the FIR (power of 2, >=2)

Ports:
clk_in  input  1  system clock (audio_clk, 98.3 MHz)
rst_in  input  1  reset, asynchronous, active-high
ch_valid_in  input  NUM_CH  per-channel one-cycle sample strobe from the i2s receivers
ch_data_in  input  NUM_CH*WIDTH  per-channel sample; channel i occupies bits [i*WIDTH +: WIDTH]
fir_tvalid_out  output  1  FIR s_axis_data_tvalid
fir_tready_in  input  1  FIR s_axis_data_tready
fir_tdata_out  output  WIDTH  FIR s_axis_data_tdata
fir_res_valid_in  input  1  FIR m_axis_data_tvalid
fir_res_data_in  input  WIDTH  FIR m_axis_data_tdata
ch_valid_out  output  NUM_CH  one-cycle strobe: filtered sample available for channel i
ch_data_out  output  NUM_CH*WIDTH  last filtered sample per channel, held between strobes
overrun_out  output  NUM_CH  sticky: channel i sample overwritten before issue
orphan_err_out  output  1  sticky: FIR result arrived with no outstanding tag

Behaviour:
- Reset (async, immediate): all outputs 0, pending flags clear, tag FIFO empty, round-robin pointer = NUM_CH-1 (channel 0 wins first).
- Capture: ch_valid_in[i] high in cycle N -> hold[i] <= data, pending[i] set at edge ending N.
- Overrun: ch_valid_in[i] while pending[i] set and channel i not loaded into issue slot this cycle -> hold[i] overwritten with new sample, overrun_out[i] set (sticky until reset). Loaded in the same cycle -> old sample issued, new one captured, pending stays set, no overrun.
- Issue slot: single register {valid, chan, data}. Loads when (slot empty OR fir_tvalid_out && fir_tready_in) AND some pending[] set AND tag FIFO not full (counting a same-cycle pop).
- Arbitration: round-robin; search starts at pointer+1 mod NUM_CH; pointer <= granted channel on load.
- Latency: ch_valid_in in cycle N with idle scheduler -> fir_tvalid_out high in cycle N+2.
- AXI rules: once fir_tvalid_out is high, fir_tdata_out and its channel remain stable until handshake; tvalid never depends combinationally on tready. Back-to-back handshakes sustain one sample per cycle.
- Tag FIFO: on handshake push the channel index; the FIR is in-order, so on fir_res_valid_in pop the head tag t -> ch_data_out[t] <= fir_res_data_in, ch_valid_out[t] pulses in cycle M+1 (result in cycle M). Simultaneous push and pop in one cycle leave occupancy unchanged. Full (TAG_DEPTH outstanding) -> no new issue.
- Orphan: fir_res_valid_in with empty tag FIFO -> result dropped, no ch_valid_out, orphan_err_out set (sticky). Covers stale FIR outputs after a mid-operation reset.
- Mid-operation reset: issued-but-unreturned samples are lost. A held fir_tvalid_out drops immediately.

Optional Feature:
FIR_SCHED_STATS_EN: defined -> extra output drop_count_out [15:0]. It increments once per overrun event and once per orphan result (+2 if both occur in the same cycle), saturates at 16'hFFFF, and resets to 0. Undefined -> the port and counter are absent; all other behaviour is identical.

Test Plan:
- Single sample: ch_valid_in=3'b001, data 16'h1234, tready=1 -> tvalid cycle N+2 with tdata 16'h1234. Return result 16'h0ABC -> ch_valid_out=3'b001 next cycle, ch_data_out[15:0]=16'h0ABC.
- Round-robin: all three channels strobe together (data 1,2,3), tready=1 -> issue order ch0,ch1,ch2 on consecutive cycles. Results 10,20,30 -> routed to ch0,ch1,ch2 respectively.
- Backpressure: tready=0 for 5 cycles with tvalid high -> tdata stable. Ch1 strobes twice meanwhile -> overrun_out=3'b010 and the newest ch1 sample is issued.
- Tag full: TAG_DEPTH=4, tready=1, no results, 6 samples pending -> exactly 4 handshakes, then tvalid low. One result returned -> one more issue.
- Orphan/reset: issue 2 samples, pulse rst_in mid-cycle (async), then return 2 results -> outputs zero immediately, no ch_valid_out, orphan_err_out=1. With FIR_SCHED_STATS_EN, drop_count_out=2.
- Same-cycle load and capture on ch0 -> one issue of the old sample, pending retained, overrun_out[0]=0.
